// File: rtl/gauss_conv_mac.sv
// Gaussian blur MAC: latches a SIZE x SIZE kernel, serially convolves one window, normalises via bit-serial division.
// Optional build macro GAUSS_CONV_ROUND_EN adds ksum/2 to the dividend for round-half-up output.
module gauss_conv_mac #(
  parameter int SIZE  = 3,
  parameter int ACC_W = 32
) (
  input  logic                              clk,
  input  logic                              n_rst,
  input  logic [SIZE-1:0][SIZE-1:0][7:0]    kernel,
  input  logic [31:0]                       ksum,
  input  logic                              kernel_load,
  output logic                              kernel_ready,
  input  logic [SIZE-1:0][SIZE-1:0][7:0]    window,
  input  logic                              window_valid,
  output logic                              window_ready,
  output logic [7:0]                        pix_out,
  output logic                              pix_valid,
  input  logic                              pix_ready
);

  localparam int RW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int CW = (ACC_W > 1) ? $clog2(ACC_W) : 1;
  localparam logic [RW-1:0] IDX_LAST = RW'(SIZE - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(ACC_W - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  logic [1:0]                       state_q, state_d;
  logic [SIZE-1:0][SIZE-1:0][7:0]   kern_q, kern_d;
  logic [31:0]                      ksum_q, ksum_d;
  logic [SIZE-1:0][SIZE-1:0][7:0]   win_q, win_d;
  logic [ACC_W-1:0]                 acc_q, acc_d;
  logic [RW-1:0]                    row_q, row_d;
  logic [RW-1:0]                    col_q, col_d;
  logic [CW-1:0]                    cnt_q, cnt_d;
  logic [ACC_W-1:0]                 rem_q, rem_d;
  logic [ACC_W-1:0]                 quo_q, quo_d;
  logic [7:0]                       pix_q, pix_d;
  logic                             pvld_q, pvld_d;

  logic [15:0]                      prod;
  logic [ACC_W-1:0]                 dvs;
  logic [ACC_W-1:0]                 rnd;
  logic [ACC_W:0]                   rem_sh;
  logic                             qbit;

  function automatic logic [7:0] sat_u8(input logic [ACC_W-1:0] q);
    return (q > ACC_W'(255)) ? 8'hFF : q[7:0];
  endfunction

  assign prod = {8'h00, kern_q[row_q][col_q]} * {8'h00, win_q[row_q][col_q]};
  assign dvs  = ACC_W'(ksum_q);

`ifdef GAUSS_CONV_ROUND_EN
  assign rnd = ACC_W'(ksum_q >> 1);
`else
  assign rnd = '0;
`endif

  // Restoring division: shift next dividend bit into the partial remainder, subtract if it fits.
  assign rem_sh = {rem_q, quo_q[ACC_W-1]};
  assign qbit   = (rem_sh >= {1'b0, dvs});

  always_comb begin
    state_d = state_q;
    kern_d  = kern_q;
    ksum_d  = ksum_q;
    win_d   = win_q;
    acc_d   = acc_q;
    row_d   = row_q;
    col_d   = col_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    pix_d   = pix_q;
    pvld_d  = pvld_q;

    case (state_q)
      S_IDLE: begin
        if (kernel_load) begin
          kern_d = kernel;
          ksum_d = ksum;
        end
        if (window_valid) begin
          win_d = window;
          acc_d = '0;
          row_d = '0;
          col_d = '0;
          // A zero weight sum cannot normalise; pass the centre pixel straight through.
          if (ksum_d == 32'd0) begin
            pix_d   = window[SIZE/2][SIZE/2];
            pvld_d  = 1'b1;
            state_d = S_OUT;
          end else begin
            state_d = S_MAC;
          end
        end
      end

      S_MAC: begin
        acc_d = acc_q + ACC_W'(prod);
        if (col_q == IDX_LAST) begin
          col_d = '0;
          row_d = row_q + 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end
        if ((row_q == IDX_LAST) && (col_q == IDX_LAST)) begin
          quo_d   = acc_d + rnd;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = S_DIV;
        end
      end

      S_DIV: begin
        rem_d = qbit ? (rem_sh[ACC_W-1:0] - dvs) : rem_sh[ACC_W-1:0];
        quo_d = {quo_q[ACC_W-2:0], qbit};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          pix_d   = sat_u8(quo_d);
          pvld_d  = 1'b1;
          state_d = S_OUT;
        end
      end

      S_OUT: begin
        if (pix_ready) begin
          pvld_d  = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      kern_q  <= '0;
      ksum_q  <= '0;
      win_q   <= '0;
      acc_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      pix_q   <= '0;
      pvld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      kern_q  <= kern_d;
      ksum_q  <= ksum_d;
      win_q   <= win_d;
      acc_q   <= acc_d;
      row_q   <= row_d;
      col_q   <= col_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      pix_q   <= pix_d;
      pvld_q  <= pvld_d;
    end
  end

  assign kernel_ready = (state_q == S_IDLE);
  assign window_ready = (state_q == S_IDLE);
  assign pix_out      = pix_q;
  assign pix_valid    = pvld_q;

endmodule

// File: tb/tb_gauss_conv_mac.sv
// Scoreboard bench for gauss_conv_mac: directed windows, expected pixel and latency queued at accept time.
module tb_gauss_conv_mac;
  localparam int SIZE  = 3;
  localparam int ACC_W = 32;

  typedef logic [SIZE-1:0][SIZE-1:0][7:0] mat_t;
  typedef struct {
    logic [7:0] pix;
    int         lat;
    int         acc_edge;
    string      name;
  } exp_t;

`ifdef GAUSS_CONV_ROUND_EN
  localparam logic [7:0] RND_EXP = 8'd1;
`else
  localparam logic [7:0] RND_EXP = 8'd0;
`endif

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  mat_t        kernel = '0;
  mat_t        window = '0;
  logic [31:0] ksum = '0;
  logic        kernel_load = 1'b0;
  logic        window_valid = 1'b0;
  logic        pix_ready = 1'b1;
  logic        kernel_ready, window_ready, pix_valid;
  logic [7:0]  pix_out;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  exp_t sb[$];

  gauss_conv_mac #(.SIZE(SIZE), .ACC_W(ACC_W)) dut (
    .clk(clk), .n_rst(n_rst), .kernel(kernel), .ksum(ksum), .kernel_load(kernel_load),
    .kernel_ready(kernel_ready), .window(window), .window_valid(window_valid),
    .window_ready(window_ready), .pix_out(pix_out), .pix_valid(pix_valid), .pix_ready(pix_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d expected finish earlier", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
  endtask

  function automatic mat_t fill(input logic [7:0] v);
    mat_t m;
    for (int r = 0; r < SIZE; r++)
      for (int c = 0; c < SIZE; c++) m[r][c] = v;
    return m;
  endfunction

  function automatic mat_t center(input logic [7:0] o, input logic [7:0] ctr);
    mat_t m;
    m = fill(o);
    m[SIZE/2][SIZE/2] = ctr;
    return m;
  endfunction

  // Monitor: latency measured from accept edge to first edge that sees pix_valid high
  initial begin : mon
    int   first_edge;
    logic prev_v;
    exp_t e;
    first_edge = 0;
    prev_v = 1'b0;
    forever begin
      @(negedge clk); #1;
      if (pix_valid && !prev_v) first_edge = cyc + 1;
      if (pix_valid && pix_ready) begin
        if (sb.size() == 0) chk("unexpected_pix", 1, 0);
        else begin
          e = sb.pop_front();
          chk({e.name, "_pix"}, int'(pix_out), int'(e.pix));
          chk({e.name, "_lat"}, first_edge - e.acc_edge, e.lat);
        end
      end
      prev_v = pix_valid;
    end
  end

  task automatic load(input mat_t k, input logic [31:0] s);
    int guard;
    guard = 0;
    @(negedge clk);
    kernel = k; ksum = s; kernel_load = 1'b1;
    while (!kernel_ready && guard < 500) begin @(negedge clk); guard++; end
    if (!kernel_ready) chk("load_timeout", 0, 1);
    @(negedge clk);
    kernel_load = 1'b0;
  endtask

  task automatic send(input mat_t w, input logic ld, input mat_t k, input logic [31:0] s,
                      input logic [7:0] exp_pix, input int lat, input string nm);
    int   guard;
    exp_t e;
    guard = 0;
    @(negedge clk);
    window = w; window_valid = 1'b1;
    if (ld) begin kernel = k; ksum = s; kernel_load = 1'b1; end
    while (!window_ready && guard < 500) begin @(negedge clk); guard++; end
    if (!window_ready) begin
      chk({nm, "_accept_timeout"}, 0, 1);
      window_valid = 1'b0; kernel_load = 1'b0;
      return;
    end
    e.pix = exp_pix; e.lat = lat; e.acc_edge = cyc + 1; e.name = nm;
    sb.push_back(e);
    @(negedge clk);
    window_valid = 1'b0; kernel_load = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((sb.size() != 0 || !window_ready) && guard < 200) begin @(negedge clk); guard++; end
    if (sb.size() != 0 || !window_ready) chk("drain_timeout", 0, 1);
  endtask

  initial begin : drv
    mat_t ones, gauss, asym, ramp, wa, zero;
    int   a, guard;
    ones = fill(8'd1);
    zero = '0;
    gauss = '{'{8'd1, 8'd2, 8'd1}, '{8'd2, 8'd4, 8'd2}, '{8'd1, 8'd2, 8'd1}};
    ramp  = fill(8'd0);
    for (int r = 0; r < SIZE; r++)
      for (int c = 0; c < SIZE; c++) ramp[r][c] = 8'(10 * (r * SIZE + c + 1));
    asym = '0;
    asym[0][0] = 8'd1; asym[0][1] = 8'd2; asym[0][2] = 8'd3;
    wa = '0;
    wa[0][0] = 8'd6; wa[0][1] = 8'd12; wa[0][2] = 8'd18;
    wa[1][0] = 8'd30; wa[1][1] = 8'd9; wa[2][0] = 8'd60;

    n_rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_pix_valid", int'(pix_valid), 0);
    chk("reset_window_ready", int'(window_ready), 1);
    chk("reset_kernel_ready", int'(kernel_ready), 1);
    chk("reset_pix_out", int'(pix_out), 0);
    n_rst = 1'b1;
    @(negedge clk);
    chk("post_reset_window_ready", int'(window_ready), 1);

    load(ones, 32'd9);   send(fill(8'd90), 1'b0, zero, 0, 8'd90, 42, "avg");        drain();
    load(gauss, 32'd16); send(ramp, 1'b0, zero, 0, 8'd50, 42, "gauss");             drain();
    load(asym, 32'd6);   send(wa, 1'b0, zero, 0, 8'd14, 42, "asym");                drain();
    load(ones, 32'd0);   send(center(8'd7, 8'd200), 1'b0, zero, 0, 8'd200, 1, "bypass"); drain();
    load(ones, 32'd1);   send(fill(8'd255), 1'b0, zero, 0, 8'd255, 42, "sat");      drain();
    load(ones, 32'd9);   send(center(8'd0, 8'd5), 1'b0, zero, 0, RND_EXP, 42, "round"); drain();
    send(center(8'd7, 8'd200), 1'b1, ones, 32'd0, 8'd200, 1, "same_edge_bypass");  drain();
    send(center(8'd90, 8'd180), 1'b1, ones, 32'd9, 8'd100, 42, "same_edge_load");  drain();

    // Kernel reload pulsed mid-MAC must be dropped; output then held under backpressure
    load(asym, 32'd6);
    pix_ready = 1'b0;
    send(wa, 1'b0, zero, 0, 8'd14, 42, "hazard");
    @(negedge clk);
    kernel = ones; ksum = 32'd9; kernel_load = 1'b1;
    @(negedge clk);
    kernel_load = 1'b0;
    guard = 0;
    while (!pix_valid && guard < 100) begin @(negedge clk); guard++; end
    for (int i = 0; i < 5; i++) begin
      chk("bp_pix_valid", int'(pix_valid), 1);
      chk("bp_pix_out", int'(pix_out), 14);
      chk("bp_window_ready", int'(window_ready), 0);
      @(negedge clk);
    end
    pix_ready = 1'b1;
    drain();
    load(ones, 32'd9);   send(wa, 1'b0, zero, 0, 8'd15, 42, "reload");              drain();

    // Reset sampled at accept+20 (inside DIV) aborts the in-flight window
    send(fill(8'd90), 1'b0, zero, 0, 8'd90, 42, "aborted");
    a = sb[sb.size()-1].acc_edge;
    while (cyc < a + 19) @(negedge clk);
    n_rst = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    sb.delete();
    chk("abort_pix_valid", int'(pix_valid), 0);
    chk("abort_window_ready", int'(window_ready), 1);
    chk("abort_kernel_ready", int'(kernel_ready), 1);
    chk("abort_pix_out", int'(pix_out), 0);
    repeat (45) @(negedge clk);
    chk("abort_no_partial", int'(pix_valid), 0);
    send(center(8'd7, 8'd200), 1'b0, zero, 0, 8'd200, 1, "post_reset_bypass");  drain();

    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/gauss_conv_mac.md
Name: gauss_conv_mac

Overview:
Downstream consumer of the Gaussian kernel generator. It latches the SIZE x SIZE 8-bit kernel and its 32-bit weight sum, then accepts one SIZE x SIZE pixel window at a time. For each window it computes the weighted sum serially, one MAC per cycle, and normalises it by the kernel sum with a bit-serial divider. It emits one blurred 8-bit pixel per window to the next ISP stage (FAST corner test) over a valid/ready handshake.

Parameters:
SIZE, 3, kernel/window edge length (odd, 3..9); N = SIZE*SIZE taps.
ACC_W, 32, accumulator and divider width in bits.

Ports:
clk  in  1  system clock.
n_rst  in  1  synchronous active-low reset, sampled on rising clk.
kernel  in  [SIZE-1:0][SIZE-1:0][7:0]  kernel weights, indexed [row][col].
ksum  in  32  sum of all kernel weights.
kernel_load  in  1  capture kernel/ksum this cycle (accepted only in IDLE).
kernel_ready  out  1  high in IDLE; kernel_load honoured.
window  in  [SIZE-1:0][SIZE-1:0][7:0]  pixel window, same indexing as kernel.
window_valid  in  1  window present.
window_ready  out  1  high in IDLE; transfer on window_valid && window_ready.
pix_out  out  8  normalised output pixel.
pix_valid  out  1  pix_out valid; held until pix_ready.
pix_ready  in  1  downstream accepts pix_out.

Behaviour:
- Reset (n_rst low at a rising edge, any state): state=IDLE, all kernel/ksum/window/acc/quotient registers=0, pix_out=0, pix_valid=0. window_ready=1 and kernel_ready=1 from the first cycle after reset.
- FSM states: IDLE, MAC, DIV, OUT.
- IDLE: if kernel_load, capture kernel and ksum.
- IDLE window accept: on window_valid, capture window, clear acc, set tap index t=0, go to MAC.
- Same-edge kernel_load and window accept: the window is processed with the newly loaded kernel.
- IDLE, captured ksum==0 (including one loaded this edge) on accept: bypass. pix_out=window[SIZE/2][SIZE/2], go directly to OUT.
- MAC: each cycle acc += kernel[t/SIZE][t%SIZE] * window[t/SIZE][t%SIZE]. The product is 16 bits, zero-extended to ACC_W. t runs 0..N-1. After t==N-1, go to DIV.
- MAC is exactly N cycles. Maximum acc is N*255*255 and fits in 32 bits for SIZE<=9; there is no overflow handling.
- DIV: restoring unsigned division acc / ksum, one quotient bit per cycle, MSB first. Exactly ACC_W cycles, then go to OUT.
- DIV output: pix_out = quotient saturated to 8'd255 if quotient > 255. Remainder is discarded (truncation).
- OUT: pix_valid=1 and pix_out stable. On pix_ready, pix_valid drops next cycle and state returns to IDLE.
- OUT exit timing: window_ready is high again in the cycle after the handshake. There is no pipelining or overlap.
- Latency: with the accept edge = edge 0, pix_valid is high from edge N+ACC_W+1 onward (N=9, ACC_W=32: edge 42). Bypass path: pix_valid high from edge 1.
- kernel_load outside IDLE is dropped; the in-flight result uses the kernel captured before the accept.
- window_valid outside IDLE is ignored because window_ready=0. The upstream source holds its data.
- Reset mid-MAC/DIV/OUT aborts the operation. No partial pixel is emitted.

Optional Feature:
GAUSS_CONV_ROUND_EN.
- Defined: on the MAC→DIV transition the dividend becomes acc + (ksum>>1), giving round-half-up normalisation. Saturation still applies. The bypass path is unchanged.
- Undefined: dividend = acc (truncating division). Cycle counts are identical in both builds.

Test Plan:
- Average filter: SIZE=3, kernel all 1, ksum=9, window all 90 → pix_out=90 with pix_valid rising at edge 42 after accept.
- Bypass: ksum=0, window center=200, others 7 → pix_out=200 at edge 1, no MAC/DIV cycles.
- Saturation: kernel all 1, ksum=1, window all 255 → acc=2295, pix_out=255.
- Rounding: kernel all 1, ksum=9, window center=5, others 0 → pix_out=0 without GAUSS_CONV_ROUND_EN, 1 with it.
- Backpressure/kernel hazard: hold pix_ready=0 for 5 cycles in OUT → pix_out/pix_valid stable, window_ready=0. Pulse kernel_load with new weights during MAC → ignored; result matches the old kernel. Next window after reload uses the new kernel.
- Reset mid-DIV: drop n_rst for 1 cycle at edge 20 → next cycle pix_valid=0, window_ready=1, kernel_ready=1, ksum=0. A following window with ksum=0 takes the bypass path.
